niosii_system_beam_event_ctrl: RTL and testbench



---
 rtl/niosii_system_beam_event_ctrl.sv | 170 +++++++++++++++++
 tb/tb_niosii_system_beam_event_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_beam_event_ctrl.sv
// Laser-harp beam event controller: synchronises and debounces the sensor lines,
// round-robin schedules level changes into an event FIFO popped over Avalon-MM.
module niosii_system_beam_event_ctrl #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16,
    parameter int DEB_RESET  = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [WIDTH-1:0] sync_a, sync_b, stable, pending, enable;
    logic [WIDTH-1:0] set_vec, grant_vec, pending_next;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [CNT_W-1:0] debounce;
    logic             irq_en, overflow;
    logic [4:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [3:0]       ptr, ptr_next, grant_idx;
    logic             grant_valid, grant_level;
    logic             wr_en, rd_en, pop, push, full;
    logic [31:0]      rd_mux, ctl_word;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_comb begin
        wr_en = chipselect & ~write_n;
        rd_en = chipselect & ~read_n;
        full  = (count == FULL_CNT);
        pop   = rd_en && (address == 2'd0) && (count != '0);
        push  = grant_valid && (!full || pop);
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            set_vec[i] = (sync_b[i] != stable[i]) && (cnt[i] == debounce) && enable[i];
    end

    // First pending channel at or after ptr, with wrap.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_level = 1'b0;
        grant_vec   = '0;
        ptr_next    = ptr;
        for (int k = 0; k < WIDTH; k++) begin
            idx = (int'(ptr) + k) % WIDTH;
            if (!grant_valid && pending[idx]) begin
                grant_valid    = 1'b1;
                grant_idx      = 4'(idx);
                grant_level    = stable[idx];
                grant_vec[idx] = 1'b1;
                ptr_next       = 4'((idx + 1) % WIDTH);
            end
        end
    end

    // A same-cycle set overrides the grant clear; disabling a channel drops its request.
    always_comb begin
        pending_next = (pending & ~grant_vec) | set_vec;
        if (wr_en && address == 2'd2)
            pending_next = pending_next & writedata[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync_a <= in_port;
            sync_b <= sync_a;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_b[i] != stable[i]) begin
                    if (cnt[i] == debounce) begin
                        stable[i] <= sync_b[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            ptr      <= '0;
            enable   <= '0;
            irq_en   <= 1'b0;
            debounce <= CNT_W'(DEB_RESET);
            overflow <= 1'b0;
        end else begin
            pending <= pending_next;
            if (grant_valid) ptr <= ptr_next;
            if (wr_en && address == 2'd2) begin
                enable <= writedata[WIDTH-1:0];
                irq_en <= writedata[16];
            end
            if (wr_en && address == 2'd3) debounce <= writedata[CNT_W-1:0];
            if (grant_valid && full && !pop)
                overflow <= 1'b1;
            else if (wr_en && address == 2'd1 && writedata[8])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {grant_level, grant_idx};
    end

    always_comb begin
        ctl_word           = '0;
        ctl_word[WIDTH-1:0] = enable;
        ctl_word[16]       = irq_en;
        rd_mux             = '0;
        case (address)
            2'd0: if (count != '0)
                      rd_mux = {1'b1, 22'b0, mem[rd_ptr][4], 4'b0, mem[rd_ptr][3:0]};
            2'd1: rd_mux = {23'b0, overflow, 1'b0, 7'(count)};
            2'd2: rd_mux = ctl_word;
            default: rd_mux = 32'(debounce);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (rd_en) readdata <= rd_mux;
            irq <= irq_en & ((count != '0) | overflow);
        end
    end

endmodule

// File: tb/tb_niosii_system_beam_event_ctrl.sv
// Self-checking bench: register vectors, hand-written timing corner cases and a
// randomized event stream checked against a queue-based behavioural model.
module tb_niosii_system_beam_event_ctrl;

    localparam int WIDTH      = 8;
    localparam int FIFO_DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             read_n = 1'b1;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [WIDTH-1:0] in_port = '0;
    logic [31:0]      readdata;
    logic             irq;

    niosii_system_beam_event_ctrl #(
        .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(16), .DEB_RESET(1000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Behavioural model: expected event queue, round-robin start, overflow flag.
    int          mptr;
    logic [31:0] exp_q[$];
    bit          mov;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(2);
        mptr = 0;
        exp_q.delete();
        mov = 1'b0;
    endtask

    task automatic check_reset_regs(input string tag);
        read_check(2'd0, 32'h0, {tag, "_event"});
        read_check(2'd1, 32'h0, {tag, "_status"});
        read_check(2'd2, 32'h0, {tag, "_control"});
        read_check(2'd3, 32'h3E8, {tag, "_debounce"});
        check({tag, "_irq"}, 32'(irq), 32'h0);
    endtask

    // All changed, enabled channels fire together; they are granted in order
    // starting at the round-robin pointer, dropped once the FIFO is full.
    task automatic model_change(input logic [7:0] old_v, input logic [7:0] new_v, input logic [7:0] en);
        int last;
        int ch;
        last = -1;
        for (int k = 0; k < WIDTH; k++) begin
            ch = (mptr + k) % WIDTH;
            if (old_v[ch] != new_v[ch] && en[ch]) begin
                if (exp_q.size() < FIFO_DEPTH)
                    exp_q.push_back(32'h8000_0000 | (32'(new_v[ch]) << 8) | 32'(ch));
                else
                    mov = 1'b1;
                last = ch;
            end
        end
        if (last >= 0) mptr = (last + 1) % WIDTH;
    endtask

    task automatic drain_check(input string tag);
        int n;
        n = exp_q.size();
        read_check(2'd1, 32'(n) | (32'(mov) << 8), {tag, "_count"});
        for (int i = 0; i < n; i++) read_check(2'd0, exp_q.pop_front(), {tag, "_pop"});
        read_check(2'd0, 32'h0, {tag, "_empty"});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  cur, nv, en, mask;
        int          len;

        @(negedge clk);
        idle(2);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        idle(2);
        mptr = 0;
        mov = 1'b0;
        check_reset_regs("por");

        vecs.push_back('{1'b1, 2'd2, 32'hFFFF_00A5, 32'h0, "ctl_wr"});
        vecs.push_back('{1'b0, 2'd2, 32'h0, 32'h0001_00A5, "ctl_rd"});
        vecs.push_back('{1'b1, 2'd3, 32'hFFFF_1234, 32'h0, "deb_wr"});
        vecs.push_back('{1'b0, 2'd3, 32'h0, 32'h0000_1234, "deb_rd"});
        vecs.push_back('{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0, "evt_wr"});
        vecs.push_back('{1'b0, 2'd0, 32'h0, 32'h0, "evt_rd_ignored_wr"});
        vecs.push_back('{1'b1, 2'd1, 32'hFFFF_FEFF, 32'h0, "stat_wr"});
        vecs.push_back('{1'b0, 2'd1, 32'h0, 32'h0, "stat_rd_ignored_wr"});
        vecs.push_back('{1'b1, 2'd2, 32'h0000_0000, 32'h0, "ctl_wr0"});
        vecs.push_back('{1'b0, 2'd2, 32'h0, 32'h0, "ctl_rd0"});
        vecs.push_back('{1'b1, 2'd3, 32'h0000_0000, 32'h0, "deb_wr0"});
        vecs.push_back('{1'b0, 2'd3, 32'h0, 32'h0, "deb_rd0"});
        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        check("vec_irq", 32'(irq), 32'h0);

        // Pending at edge 7, FIFO push at edge 8, registered irq at edge 9.
        bus_write(2'd3, 32'd4);
        bus_write(2'd2, 32'h0001_00FF);
        in_port = 8'h08;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("lat_irq_e%0d", k), 32'(irq), (k >= 9) ? 32'h1 : 32'h0);
        end
        read_check(2'd0, 32'h8000_0103, "lat_event");
        read_check(2'd1, 32'h0, "lat_count");
        check("lat_irq_clr", 32'(irq), 32'h0);

        in_port = 8'h28;
        idle(3);
        in_port = 8'h08;
        idle(20);
        read_check(2'd1, 32'h0, "glitch_count");
        check("glitch_irq", 32'(irq), 32'h0);

        in_port = 8'h00;
        do_reset();
        bus_write(2'd3, 32'd0);
        bus_write(2'd2, 32'h0001_00FF);
        in_port = 8'hFF;
        idle(20);
        for (int i = 0; i < 8; i++)
            read_check(2'd0, 32'h8000_0100 | 32'(i), $sformatf("burst_ch%0d", i));
        read_check(2'd0, 32'h0, "burst_empty");

        in_port = 8'h00; model_change(8'hFF, 8'h00, 8'hFF); idle(20);
        in_port = 8'hFF; model_change(8'h00, 8'hFF, 8'hFF); idle(20);
        in_port = 8'hFE; model_change(8'hFF, 8'hFE, 8'hFF); idle(20);
        check("ovf_irq", 32'(irq), 32'h1);
        drain_check("ovf");
        check("ovf_irq_hold", 32'(irq), 32'h1);
        bus_write(2'd1, 32'h100);
        mov = 1'b0;
        read_check(2'd1, 32'h0, "ovf_cleared");
        idle(1);
        check("ovf_irq_clr", 32'(irq), 32'h0);

        // Full FIFO: ch2 request timed so the pop lands on the grant cycle.
        in_port = 8'h01; model_change(8'hFE, 8'h01, 8'hFF); idle(20);
        in_port = 8'hFE; model_change(8'h01, 8'hFE, 8'hFF); idle(20);
        read_check(2'd1, 32'h10, "full_count");
        in_port = 8'hFA;
        idle(3);
        bus_read(2'd0, d);
        check("full_pop_head", d, exp_q.pop_front());
        model_change(8'hFE, 8'hFA, 8'hFF);
        check("full_tail_ch2", exp_q[exp_q.size() - 1], 32'h8000_0002);
        drain_check("full");

        in_port = 8'h5A;
        idle(4);
        reset_n = 1'b0;
        #1;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        idle(1);
        in_port = 8'h00;
        idle(2);
        reset_n = 1'b1;
        idle(2);
        mptr = 0;
        exp_q.delete();
        mov = 1'b0;
        check_reset_regs("midrst");

        bus_write(2'd3, 32'd3);
        cur = 8'h00;
        for (int r = 0; r < 40; r++) begin
            en = 8'($urandom_range(0, 255));
            bus_write(2'd2, 32'h0001_0000 | 32'(en));
            if ($urandom_range(0, 3) == 0) begin
                mask = 8'($urandom_range(1, 255));
                len = $urandom_range(1, 3);
                in_port = cur ^ mask;
                idle(len);
                in_port = cur;
                idle(15);
                read_check(2'd1, 32'h0, $sformatf("rnd%0d_glitch", r));
                check($sformatf("rnd%0d_glitch_irq", r), 32'(irq), 32'h0);
            end else begin
                nv = 8'($urandom_range(0, 255));
                in_port = nv;
                model_change(cur, nv, en);
                cur = nv;
                idle(20);
                check($sformatf("rnd%0d_irq", r), 32'(irq), (exp_q.size() != 0) ? 32'h1 : 32'h0);
                drain_check($sformatf("rnd%0d", r));
                check($sformatf("rnd%0d_irq_clr", r), 32'(irq), 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
